// File: rtl/tl_phase_scheduler.sv
// Four-approach traffic-light phase scheduler with turn and side/pedestrian phases.
// Optional emergency preemption is built in when the macro TL_EMG_PREEMPT_EN is defined.
module tl_phase_scheduler #(
   parameter int T_MIN_MAIN = 19,
   parameter int T_YELLOW   = 4,
   parameter int T_ALLRED   = 1,
   parameter int T_TURN     = 14,
   parameter int T_SIDE     = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_turn,
   input  logic       req_side,
   input  logic       req_ped,
   input  logic       emg_req,
   output logic [2:0] light_M1,
   output logic [2:0] light_M2,
   output logic [2:0] light_M1Turn,
   output logic [2:0] light_Side,
   output logic       ped_walk,
   output logic       emg_active,
   output logic [3:0] phase
);

   typedef enum logic [3:0] {
      MAIN_GRN = 4'd0,
      M2_YEL   = 4'd1,
      TURN_GRN = 4'd2,
      TURN_YEL = 4'd3,
      M1_YEL   = 4'd4,
      MAIN_YEL = 4'd5,
      ALLRED   = 4'd6,
      SIDE_GRN = 4'd7,
      SIDE_YEL = 4'd8
   } state_t;

   localparam logic [4:0] C_MIN  = 5'(T_MIN_MAIN);
   localparam logic [4:0] C_YEL  = 5'(T_YELLOW);
   localparam logic [4:0] C_AR   = 5'(T_ALLRED);
   localparam logic [4:0] C_TURN = 5'(T_TURN);
   localparam logic [4:0] C_SIDE = 5'(T_SIDE);

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   state_t     state, state_nxt;
   logic [4:0] cnt, cnt_nxt;
   logic       turn_pend, side_pend, ped_pend;
   logic       emg;
   logic       enter_turn, enter_side;

`ifdef TL_EMG_PREEMPT_EN
   assign emg = emg_req;
`else
   logic unused_emg;
   assign unused_emg = emg_req;
   assign emg        = 1'b0;
`endif

   // Lamp code order: M1, M2, M1Turn, Side; illegal codes fall back to all red.
   function automatic logic [11:0] lamps(input state_t s);
      case (s)
         MAIN_GRN: lamps = {GRN, GRN, RED, RED};
         M2_YEL:   lamps = {GRN, YEL, RED, RED};
         TURN_GRN: lamps = {GRN, RED, GRN, RED};
         TURN_YEL: lamps = {GRN, RED, YEL, RED};
         M1_YEL:   lamps = {YEL, RED, RED, RED};
         MAIN_YEL: lamps = {YEL, YEL, RED, RED};
         SIDE_GRN: lamps = {RED, RED, RED, GRN};
         SIDE_YEL: lamps = {RED, RED, RED, YEL};
         default:  lamps = {RED, RED, RED, RED};
      endcase
   endfunction

   always_comb begin
      state_nxt = state;
      case (state)
         MAIN_GRN: if (cnt == C_MIN && !emg) begin
            if (turn_pend)                  state_nxt = M2_YEL;
            else if (side_pend || ped_pend) state_nxt = MAIN_YEL;
         end
         M2_YEL:   if (cnt == C_YEL) state_nxt = TURN_GRN;
         TURN_GRN: if (emg || cnt == C_TURN) state_nxt = TURN_YEL;
         // Under preemption M1 keeps its green rather than handing over to the side road.
         TURN_YEL: if (cnt == C_YEL)
            state_nxt = ((side_pend || ped_pend) && !emg) ? M1_YEL : MAIN_GRN;
         M1_YEL,
         MAIN_YEL: if (cnt == C_YEL) state_nxt = ALLRED;
         ALLRED:   if (cnt == C_AR) state_nxt = emg ? MAIN_GRN : SIDE_GRN;
         SIDE_GRN: if (emg || cnt == C_SIDE) state_nxt = SIDE_YEL;
         SIDE_YEL: if (cnt == C_YEL) state_nxt = MAIN_GRN;
         default:  state_nxt = ALLRED;
      endcase
   end

   always_comb begin
      if (state_nxt != state)                      cnt_nxt = 5'd0;
      else if (state == MAIN_GRN && cnt == C_MIN) cnt_nxt = cnt;
      else                                         cnt_nxt = cnt + 5'd1;
   end

   assign enter_turn = (state_nxt == TURN_GRN) && (state != TURN_GRN);
   assign enter_side = (state_nxt == SIDE_GRN) && (state != SIDE_GRN);

   // Outputs are decoded from the next state so they switch on the same edge as it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= MAIN_GRN;
         cnt        <= 5'd0;
         turn_pend  <= 1'b0;
         side_pend  <= 1'b0;
         ped_pend   <= 1'b0;
         {light_M1, light_M2, light_M1Turn, light_Side} <= lamps(MAIN_GRN);
         ped_walk   <= 1'b0;
         emg_active <= 1'b0;
         phase      <= 4'd0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         turn_pend  <= enter_turn ? 1'b0 : (turn_pend || (req_turn && state != TURN_GRN));
         side_pend  <= enter_side ? 1'b0 : (side_pend || (req_side && state != SIDE_GRN));
         ped_pend   <= enter_side ? 1'b0 : (ped_pend  || (req_ped  && state != SIDE_GRN));
         {light_M1, light_M2, light_M1Turn, light_Side} <= lamps(state_nxt);
         ped_walk   <= (state_nxt == SIDE_GRN) && ((state == SIDE_GRN) ? ped_walk : ped_pend);
         emg_active <= emg;
         phase      <= state_nxt;
      end
   end

endmodule

// File: doc/tl_phase_scheduler.md
TL_PHASE_SCHEDULER -- requirements
Module: tl_phase_scheduler

Interface
REQ-001 SHALL expose parameter T_MIN_MAIN, default 19, minimum main-phase green length minus 1 (cycles).
REQ-002 SHALL expose parameter T_YELLOW, default 4, yellow length minus 1.
REQ-003 SHALL expose parameter T_ALLRED, default 1, all-red length minus 1.
REQ-004 SHALL expose parameter T_TURN, default 14, turn-phase green length minus 1.
REQ-005 SHALL expose parameter T_SIDE, default 9, side-phase green length minus 1; every T_* parameter is in the range 0..31.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 req_turn  in  1  M1-to-side turn vehicle detector (level or pulse).
REQ-010 req_side  in  1  side-road vehicle detector.
REQ-011 req_ped  in  1  pedestrian button for crossing M1.
REQ-012 emg_req  in  1  emergency preemption request (main road).
REQ-013 light_M1, light_M2, light_M1Turn, light_Side  out  3 each  lamp code: 100 = red, 010 = yellow, 001 = green.
REQ-014 ped_walk  out  1  walk signal.
REQ-015 emg_active  out  1  preemption in force.
REQ-016 phase  out  4  current state code, for debug.

Function
REQ-017 SHALL implement these states and codes, each with the lamp outputs M1/M2/Turn/Side:
- MAIN_GRN = 0: G/G/R/R
- M2_YEL = 1: G/Y/R/R
- TURN_GRN = 2: G/R/G/R
- TURN_YEL = 3: G/R/Y/R
- M1_YEL = 4: Y/R/R/R
- MAIN_YEL = 5: Y/Y/R/R
- ALLRED = 6: R/R/R/R
- SIDE_GRN = 7: R/R/R/G
- SIDE_YEL = 8: R/R/R/Y
REQ-018 Lamps, ped_walk, emg_active and phase SHALL be registered and SHALL change on the same edge as the state, with no extra latency.
REQ-019 A 5-bit counter SHALL clear on every state change and increment otherwise; a timed state of length D SHALL last exactly D+1 cycles.
REQ-020 Each request input SHALL set its own pending latch (turn_pend, side_pend, ped_pend) one cycle after it is sampled high; a latch SHALL hold until its phase is served.
REQ-021 A request sampled while its own green is active SHALL be dropped. req_ped SHALL count as a side-phase request.
REQ-022 turn_pend SHALL clear on the edge that enters TURN_GRN; side_pend and ped_pend SHALL clear on the edge that enters SIDE_GRN; clear SHALL win over a simultaneous set.
REQ-023 MAIN_GRN is the rest state: the counter saturates at T_MIN_MAIN.
REQ-024 MAIN_GRN exit, once the counter equals T_MIN_MAIN:
- turn_pend set -> M2_YEL
- else side_pend or ped_pend set -> MAIN_YEL
- else remain in MAIN_GRN
REQ-025 Other timed transitions:
- M2_YEL (T_YELLOW) -> TURN_GRN
- TURN_GRN (T_TURN) -> TURN_YEL
- TURN_YEL (T_YELLOW) -> M1_YEL if side/ped pending, else MAIN_GRN
- M1_YEL and MAIN_YEL (T_YELLOW) -> ALLRED
- ALLRED (T_ALLRED) -> SIDE_GRN
- SIDE_GRN (T_SIDE) -> SIDE_YEL
- SIDE_YEL (T_YELLOW) -> MAIN_GRN
REQ-026 ped_walk SHALL assert for all of SIDE_GRN when ped_pend was set at SIDE_GRN entry, and SHALL deassert on SIDE_YEL entry.
REQ-027 A yellow or all-red state SHALL never be shortened. An illegal state code SHALL go to ALLRED with all lamps red, then proceed to SIDE_GRN or MAIN_GRN per REQ-025.

Reset
REQ-028 When rst is high at an edge, the block SHALL set state MAIN_GRN, counter 0, all latches 0, lamps M1=001 M2=001 Turn=100 Side=100, ped_walk 0, emg_active 0, phase 0.
REQ-029 Reset SHALL take priority over every transition, including mid-phase; requests sampled while rst is high SHALL be ignored.

Configuration
REQ-030 Macro TL_EMG_PREEMPT_EN SHALL select emergency preemption. When defined, emg_req high SHALL:
- end TURN_GRN or SIDE_GRN on the next edge, entering its yellow
- send ALLRED to MAIN_GRN
- hold MAIN_GRN regardless of pending requests
- assert emg_active from the next edge until emg_req is sampled low
Pending latches SHALL be retained through preemption and served afterwards.
REQ-031 Without TL_EMG_PREEMPT_EN, the emg_req port SHALL exist but be ignored, and emg_active SHALL be constant 0.

Verification
REQ-032 Reset, then no requests for 200 cycles -> phase stays 0; lamps 001/001/100/100; ped_walk 0.
REQ-033 req_turn pulse 3 cycles after reset -> MAIN_GRN 20 cycles, M2_YEL 5, TURN_GRN 15, TURN_YEL 5, then MAIN_GRN rest.
REQ-034 req_turn, req_side and req_ped pulsed together -> turn sequence, then TURN_YEL -> M1_YEL 5, ALLRED 2, SIDE_GRN 10 with ped_walk=1, SIDE_YEL 5, then MAIN_GRN.
REQ-035 req_side pulsed during SIDE_GRN -> dropped; after SIDE_YEL the block rests in MAIN_GRN.
REQ-036 rst asserted at TURN_GRN counter 7 with side_pend set -> next cycle phase 0, lamps at reset values, side_pend 0.
REQ-037 With TL_EMG_PREEMPT_EN, emg_req raised at SIDE_GRN counter 3 for 30 cycles -> SIDE_YEL 5 cycles, then MAIN_GRN with emg_active=1; without the macro -> full SIDE_GRN of 10 cycles and emg_active=0.
